locked_seq_multiplier: RTL and testbench

LOCKED_SEQ_MULTIPLIER -- requirements
Module: locked_seq_multiplier

---
 rtl/lock_mult_pkg.sv | 12 +
 rtl/lock_mask_gen.sv | 15 +
 rtl/locked_seq_multiplier.sv | 118 +++++++++++
 tb/tb_locked_seq_multiplier.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_mult_pkg.sv
// rtl/lock_mult_pkg.sv - shared FSM state type and default unlock key for the locked multiplier
package lock_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_LOCK_KEY = 32'hA5C3_0F96;

endpackage

// File: rtl/lock_mask_gen.sv
// rtl/lock_mask_gen.sv - replicates the key mismatch vector across the product width
module lock_mask_gen #(
  parameter int KEY_WIDTH = 32,
  parameter int OUT_WIDTH = 16
) (
  input  logic [KEY_WIDTH-1:0] i_mismatch,
  output logic [OUT_WIDTH-1:0] o_mask
);

  // Mask bit j takes mismatch bit (j mod KEY_WIDTH), so a short key wraps around the product.
  for (genvar j = 0; j < OUT_WIDTH; j++) begin : g_mask
    assign o_mask[j] = i_mismatch[j % KEY_WIDTH];
  end

endmodule

// File: rtl/locked_seq_multiplier.sv
// rtl/locked_seq_multiplier.sv - key-locked shift-add multiplier, one multiplier bit per cycle
module locked_seq_multiplier
  import lock_mult_pkg::*;
#(
  parameter int                   WIDTH     = 8,
  parameter int                   KEY_WIDTH = 32,
  parameter logic [KEY_WIDTH-1:0] LOCK_KEY  = KEY_WIDTH'(DEFAULT_LOCK_KEY)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   key_load_i,
  input  logic [KEY_WIDTH-1:0]   keyinput,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WIDTH-1:0]       op1_i,
  input  logic [WIDTH-1:0]       op2_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [2*WIDTH-1:0]     product_o,
  output logic                   key_err_o
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [KEY_WIDTH-1:0] r_key_q;
  logic                 r_key_err;
  logic [PW-1:0]        r_acc;
  logic [PW-1:0]        r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_last;
  logic [PW-1:0]        w_addend;
  logic [PW-1:0]        w_mask;

  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_addend = r_mplier[0] ? r_mcand : '0;

  lock_mask_gen #(
    .KEY_WIDTH (KEY_WIDTH),
    .OUT_WIDTH (PW)
  ) u_mask_gen (
    .i_mismatch (r_key_q ^ LOCK_KEY),
    .o_mask     (w_mask)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: accept in IDLE, WIDTH run cycles, hold in DONE until consumed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid_i)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)      w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready_i) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // Shift-add datapath: multiplicand shifts left, multiplier shifts right, LSB gates the add.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid_i) begin
            r_mcand  <= {{WIDTH{1'b0}}, op1_i};
            r_mplier <= op2_i;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        ST_RUN: begin
          r_acc    <= r_acc + w_addend;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (!w_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Key register: loads only in IDLE; a load attempt while busy is refused and flagged for one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_key_q   <= '0;
      r_key_err <= 1'b0;
    end else begin
      r_key_err <= key_load_i && (r_state != ST_IDLE);
      if (key_load_i && (r_state == ST_IDLE)) begin
        r_key_q <= keyinput;
      end
    end
  end

  assign in_ready_o  = (r_state == ST_IDLE);
  assign out_valid_o = (r_state == ST_DONE);
  assign product_o   = (r_state == ST_DONE) ? (r_acc ^ w_mask) : '0;
  assign key_err_o   = r_key_err;

endmodule

// File: tb/tb_locked_seq_multiplier.sv
// tb/tb_locked_seq_multiplier.sv - directed self-checking bench for locked_seq_multiplier
module tb_locked_seq_multiplier;

  localparam int          WIDTH     = 8;
  localparam int          KEY_WIDTH = 32;
  localparam logic [31:0] GOOD_KEY  = 32'hA5C3_0F96;
  localparam logic [31:0] BAD_KEY   = 32'hA5C3_0F97;

  logic                 clk_i;
  logic                 rst_ni;
  logic                 key_load_i;
  logic [KEY_WIDTH-1:0] keyinput;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [WIDTH-1:0]     op1_i;
  logic [WIDTH-1:0]     op2_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [2*WIDTH-1:0]   product_o;
  logic                 key_err_o;

  int n_cmp;
  int n_bad;
  int cyc;

  locked_seq_multiplier #(
    .WIDTH     (WIDTH),
    .KEY_WIDTH (KEY_WIDTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .key_load_i  (key_load_i),
    .keyinput    (keyinput),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .product_o   (product_o),
    .key_err_o   (key_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Stimulus helpers; each starts and ends 1ns after a rising edge.
  task automatic load_key(input logic [31:0] k);
    key_load_i = 1'b1;
    keyinput   = k;
    @(posedge clk_i); #1;
    key_load_i = 1'b0;
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    in_valid_i = 1'b1;
    op1_i      = a;
    op2_i      = b;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    op1_i      = 8'hFF;
    op2_i      = 8'hFF;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!out_valid_o && edges < 50) begin
      @(posedge clk_i); #1;
      edges++;
    end
    n_cmp++;
    if (!out_valid_o) begin
      n_bad++;
      $display("FAIL wait_done: out_valid_o=%0b after %0d edges, required 1", out_valid_o, edges);
    end
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready_o, out_valid_o, product_o, key_err_o} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%0b vld=%0b prod=%h err=%0b, required 1 0 0000 0",
               in_ready_o, out_valid_o, product_o, key_err_o);
    end
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_correct_key();
    int edges;
    load_key(GOOD_KEY);
    start_op(8'd13, 8'd11);
    n_cmp++;
    if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL run_handshake: rdy=%0b vld=%0b, required 0 0", in_ready_o, out_valid_o);
    end
    wait_done(edges);
    n_cmp++;
    if (edges !== 8) begin
      n_bad++;
      $display("FAIL latency: %0d edges after accept, required 8", edges);
    end
    n_cmp++;
    if (product_o !== 16'h008F) begin
      n_bad++;
      $display("FAIL good_key_13x11: product=%h, required 008f", product_o);
    end
    drain();
    n_cmp++;
    if (in_ready_o !== 1'b1 || product_o !== 16'h0000) begin
      n_bad++;
      $display("FAIL drain_idle: rdy=%0b prod=%h, required 1 0000", in_ready_o, product_o);
    end
  endtask

  task automatic test_wrong_key();
    int edges;
    load_key(BAD_KEY);
    start_op(8'd13, 8'd11);
    wait_done(edges);
    n_cmp++;
    if (product_o !== 16'h008E) begin
      n_bad++;
      $display("FAIL bad_key_13x11: product=%h, required 008e", product_o);
    end
    drain();
  endtask

  task automatic test_operands();
    int edges;
    // Key load and accept on the same edge: the new key must govern this operation.
    key_load_i = 1'b1;
    keyinput   = GOOD_KEY;
    start_op(8'd255, 8'd255);
    key_load_i = 1'b0;
    wait_done(edges);
    n_cmp++;
    if (product_o !== 16'hFE01) begin
      n_bad++;
      $display("FAIL max_255x255: product=%h, required fe01", product_o);
    end
    drain();
    start_op(8'd0, 8'd200);
    wait_done(edges);
    n_cmp++;
    if (product_o !== 16'h0000) begin
      n_bad++;
      $display("FAIL zero_0x200: product=%h, required 0000", product_o);
    end
    drain();
    start_op(8'd200, 8'd1);
    wait_done(edges);
    n_cmp++;
    if (product_o !== 16'h00C8) begin
      n_bad++;
      $display("FAIL one_200x1: product=%h, required 00c8", product_o);
    end
    drain();
    start_op(8'd128, 8'd128);
    wait_done(edges);
    n_cmp++;
    if (product_o !== 16'h4000) begin
      n_bad++;
      $display("FAIL msb_128x128: product=%h, required 4000", product_o);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int edges;
    start_op(8'd37, 8'd19);
    wait_done(edges);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (product_o !== 16'h02BF || out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_%0d: prod=%h vld=%0b rdy=%0b, required 02bf 1 0",
                 i, product_o, out_valid_o, in_ready_o);
      end
      @(posedge clk_i); #1;
    end
    drain();
    n_cmp++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL release_idle: rdy=%0b vld=%0b, required 1 0", in_ready_o, out_valid_o);
    end
  endtask

  task automatic test_key_err_in_run();
    int edges;
    start_op(8'd13, 8'd11);
    @(posedge clk_i); #1;
    in_valid_i = 1'b1;
    op1_i      = 8'd99;
    op2_i      = 8'd77;
    load_key(32'h1234_5678);
    in_valid_i = 1'b0;
    n_cmp++;
    if (key_err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL key_err_pulse: key_err_o=%0b, required 1", key_err_o);
    end
    @(posedge clk_i); #1;
    n_cmp++;
    if (key_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL key_err_width: key_err_o=%0b, required 0", key_err_o);
    end
    wait_done(edges);
    n_cmp++;
    if (product_o !== 16'h008F) begin
      n_bad++;
      $display("FAIL key_kept: product=%h, required 008f", product_o);
    end
    drain();
  endtask

  task automatic test_reset_mid_run();
    int edges;
    start_op(8'd13, 8'd11);
    repeat (3) begin
      @(posedge clk_i); #1;
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready_o, out_valid_o, product_o, key_err_o} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_run: rdy=%0b vld=%0b prod=%h err=%0b, required 1 0 0000 0",
               in_ready_o, out_valid_o, product_o, key_err_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    edges = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_i); #1;
      if (out_valid_o) edges++;
    end
    n_cmp++;
    if (edges !== 0) begin
      n_bad++;
      $display("FAIL abort_no_product: %0d valid cycles after reset, required 0", edges);
    end
    start_op(8'd13, 8'd11);
    wait_done(edges);
    n_cmp++;
    if (product_o !== 16'h0F19) begin
      n_bad++;
      $display("FAIL unkeyed_13x11: product=%h, required 0f19", product_o);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int acc_cyc[3];
    int n_acc;
    int guard;
    load_key(GOOD_KEY);
    in_valid_i  = 1'b1;
    op1_i       = 8'd3;
    op2_i       = 8'd5;
    out_ready_i = 1'b1;
    n_acc = 0;
    guard = 0;
    while (n_acc < 3 && guard < 60) begin
      @(negedge clk_i);
      guard++;
      if (in_ready_o) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (out_valid_o && product_o !== 16'h000F) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b2b_product: product=%h, required 000f", product_o);
      end
    end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    n_cmp++;
    if (n_acc !== 3) begin
      n_bad++;
      $display("FAIL b2b_accepts: %0d accepts, required 3", n_acc);
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_cmp++;
        if (acc_cyc[i] - acc_cyc[i-1] !== 10) begin
          n_bad++;
          $display("FAIL b2b_interval_%0d: %0d cycles, required 10", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
    repeat (12) begin
      @(posedge clk_i); #1;
    end
    out_ready_i = 1'b0;
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    cyc         = 0;
    rst_ni      = 1'b1;
    key_load_i  = 1'b0;
    keyinput    = '0;
    in_valid_i  = 1'b0;
    op1_i       = '0;
    op2_i       = '0;
    out_ready_i = 1'b0;
    #2;
    test_reset();
    test_correct_key();
    test_wrong_key();
    test_operands();
    test_backpressure();
    test_key_err_in_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
